// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Bits needed to hold 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous pin; reset value is a parameter.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W = clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rxs;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                 par_ok;
`endif

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            clk_cnt <= (clk_cnt == CNT_LAST) ? '0 : clk_cnt + 1'b1;
            // A commit below overrides this drain in the same cycle.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rxs)
                        state <= START;
                end
                START: begin
                    if (clk_cnt == CNT_MID) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == CNT_LAST) begin
                        par_ok <= (rxs == ^shift_reg);
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (!par_ok)
                                parity_err <= 1'b1;
                            else
`endif
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    clk_cnt <= '0;
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
